// File: rtl/ser_arb_pkg.sv
// ---------------------------------------------------------------------------
// ser_arb_pkg
// Shared types and default sizes for the serializer arbiter slice.
//   ser_arb_state_t  : arbiter FSM state encoding (IDLE, LOAD, STREAM, ACK)
//   SER_ELEMENT_BITS : default bits per element
//   SER_FEATURES     : default elements per vector
// ---------------------------------------------------------------------------
package ser_arb_pkg;

  localparam int SER_ELEMENT_BITS = 8;
  localparam int SER_FEATURES     = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    STREAM = 2'd2,
    ACK    = 2'd3
  } ser_arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin pick: returns the first asserted request at or
// after ptr, wrapping modulo NUM_REQ. Holds no state; the owner keeps ptr.
// Ports:
//   req       in  NUM_REQ  request levels
//   ptr       in  IW       highest-priority index for this pick
//   gnt_idx   out IW       chosen requester (0 when none)
//   gnt_valid out 1        some request is asserted
// ---------------------------------------------------------------------------
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic [IW-1:0]      gnt_idx,
  output logic               gnt_valid
);

  // Walk offsets 0..NUM_REQ-1 from ptr; the first hit wins and later
  // offsets are masked by gnt_valid.
  always_comb begin
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    for (int off = 0; off < NUM_REQ; off++) begin
      for (int j = 0; j < NUM_REQ; j++) begin
        if (!gnt_valid && req[j] && (((int'(ptr) + off) % NUM_REQ) == j)) begin
          gnt_idx   = IW'(j);
          gnt_valid = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/serializer_arbiter.sv
// ---------------------------------------------------------------------------
// serializer_arbiter
// Shares one serializer between NUM_REQ vector producers. A round-robin
// winner's vector is latched, handed to the serializer with a one-cycle
// ser_start, the returned element stream is tagged with the owner index, and
// the owner gets a one-cycle ack once its last element has been forwarded.
//
// Optional feature (macro SER_ARB_ERR_CHK_EN): checks that ser_done is high
// exactly with the last element of each vector and low at all other times;
// any violation sets the sticky err output until reset. Without the macro
// err is tied low and ser_done is ignored.
//
// Handshake: req is a level held (with its data slice) until ack; ack is a
// single-cycle pulse at completion. The consumer side has no backpressure:
// out_valid marks a valid out_data element in that cycle.
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   req, req_data         request levels and per-requester vectors
//   ack                   completion pulse to the served requester
//   ser_start             start pulse to the serializer
//   ser_parallel_data     vector to the serializer (stable LOAD..ACK)
//   ser_serial_data       element returned by the serializer
//   ser_done              serializer done (last element)
//   out_valid, out_data   forwarded element (out_data is 0 when not valid)
//   out_src, out_last     owner index and last-element marker
//   err                   sticky protocol error
//   state_dbg             current FSM state (ser_arb_state_t encoding)
// ---------------------------------------------------------------------------
module serializer_arbiter
  import ser_arb_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int ELEMENT_BITS = SER_ELEMENT_BITS,
  parameter int FEATURES     = SER_FEATURES,
  parameter int IW           = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  parameter int VW           = ELEMENT_BITS * FEATURES
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*VW-1:0]      req_data,
  output logic [NUM_REQ-1:0]         ack,
  output logic                       ser_start,
  output logic [VW-1:0]              ser_parallel_data,
  input  logic [ELEMENT_BITS-1:0]    ser_serial_data,
  input  logic                       ser_done,
  output logic                       out_valid,
  output logic [ELEMENT_BITS-1:0]    out_data,
  output logic [IW-1:0]              out_src,
  output logic                       out_last,
  output logic                       err,
  output logic [1:0]                 state_dbg
);

  localparam int CW = $clog2(FEATURES + 1);

  ser_arb_state_t    state;
  logic [IW-1:0]     grant;
  logic [IW-1:0]     ptr;
  logic [CW-1:0]     cnt;
  logic [VW-1:0]     par_q;

  logic [IW-1:0]     arb_idx;
  logic              arb_valid;
  logic [VW-1:0]     sel_vec;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IW      (IW)
  ) u_rr_arbiter (
    .req       (req),
    .ptr       (ptr),
    .gnt_idx   (arb_idx),
    .gnt_valid (arb_valid)
  );

  // Slice of the winning requester.
  always_comb begin
    sel_vec = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_idx == IW'(i)) sel_vec = req_data[i*VW +: VW];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      grant <= '0;
      ptr   <= '0;
      cnt   <= '0;
      par_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (arb_valid) begin
            grant <= arb_idx;
            par_q <= sel_vec;
            state <= LOAD;
          end
        end
        LOAD: begin
          cnt   <= '0;
          state <= STREAM;
        end
        STREAM: begin
          cnt <= cnt + CW'(1);
          if (cnt == CW'(FEATURES - 1)) state <= ACK;
        end
        ACK: begin
          // The served requester drops to lowest priority for the next pick.
          ptr   <= (grant == IW'(NUM_REQ - 1)) ? '0 : grant + IW'(1);
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs decode directly from the state/count registers, so they are
  // all zero while reset is held.
  always_comb begin
    ack = '0;
    if (state == ACK) ack[grant] = 1'b1;
  end

  assign ser_start         = (state == LOAD);
  assign ser_parallel_data = par_q;
  assign out_valid         = (state == STREAM);
  assign out_last          = out_valid && (cnt == CW'(FEATURES - 1));
  assign out_data          = out_valid ? ser_serial_data : '0;
  assign out_src           = out_valid ? grant : '0;
  assign state_dbg         = state;

`ifdef SER_ARB_ERR_CHK_EN
  logic err_q;

  // ser_done is expected exactly when the last element is being forwarded.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_q <= 1'b0;
    end else if (ser_done != out_last) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  logic unused_ser_done;

  assign unused_ser_done = ser_done;
  assign err             = 1'b0;
`endif

endmodule

// File: tb/tb_serializer_arbiter.sv
// ---------------------------------------------------------------------------
// tb_serializer_arbiter
// Scoreboard bench: directed stimulus pushes expected elements and acks into
// queues; a negedge monitor pops and compares whatever the DUT presents.
// A small behavioural serializer answers ser_start.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_serializer_arbiter;

  localparam int NUM_REQ = 4;
  localparam int EB      = 8;
  localparam int FEATURES = 4;
  localparam int VW      = EB * FEATURES;

`ifdef SER_ARB_ERR_CHK_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  logic                    clk;
  logic                    reset_n;
  logic [NUM_REQ-1:0]      req;
  logic [NUM_REQ*VW-1:0]   req_data;
  logic [NUM_REQ-1:0]      ack;
  logic                    ser_start;
  logic [VW-1:0]           ser_parallel_data;
  logic [EB-1:0]           ser_serial_data;
  logic                    ser_done;
  logic                    out_valid;
  logic [EB-1:0]           out_data;
  logic [1:0]              out_src;
  logic                    out_last;
  logic                    err;
  logic [1:0]              state_dbg;

  serializer_arbiter dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .req               (req),
    .req_data          (req_data),
    .ack               (ack),
    .ser_start         (ser_start),
    .ser_parallel_data (ser_parallel_data),
    .ser_serial_data   (ser_serial_data),
    .ser_done          (ser_done),
    .out_valid         (out_valid),
    .out_data          (out_data),
    .out_src           (out_src),
    .out_last          (out_last),
    .err               (err),
    .state_dbg         (state_dbg)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- bookkeeping ----------------
  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  logic [10:0] exp_q[$];      // {src[1:0], last, data[7:0]}
  logic [3:0]  ack_q[$];
  int          ack_times[$];
  int          done_at;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_slice(input int i, input logic [31:0] v);
    for (int b = 0; b < VW; b++) req_data[i*VW + b] = v[b];
  endtask

  task automatic push_elem(input logic [1:0] src, input logic [7:0] d, input logic last);
    exp_q.push_back({src, last, d});
  endtask

  task automatic push_vec(input logic [1:0] src, input logic [31:0] v);
    for (int k = 0; k < FEATURES; k++) push_elem(src, v[k*EB +: EB], (k == FEATURES - 1));
    ack_q.push_back(4'b0001 << src);
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || ack_q.size() != 0 || req != 0) && n < budget) begin
      tick();
      n++;
    end
    if (exp_q.size() != 0 || ack_q.size() != 0 || req != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain_timeout: got %0d elems %0d acks pending expected 0", exp_q.size(), ack_q.size());
      exp_q.delete();
      ack_q.delete();
      req = '0;
    end
    tick();
  endtask

  // ---------------- behavioural serializer ----------------
  logic [VW-1:0] sm_buf;
  int            sm_k;
  logic          sm_act;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sm_buf          <= '0;
      sm_k            <= 0;
      sm_act          <= 1'b0;
      ser_serial_data <= '0;
      ser_done        <= 1'b0;
    end else if (ser_start) begin
      sm_buf          <= ser_parallel_data;
      ser_serial_data <= ser_parallel_data[EB-1:0];
      ser_done        <= (done_at == 0);
      sm_k            <= 1;
      sm_act          <= 1'b1;
    end else if (sm_act && sm_k < FEATURES) begin
      ser_serial_data <= sm_buf[sm_k*EB +: EB];
      ser_done        <= (sm_k == done_at);
      sm_k            <= sm_k + 1;
    end else begin
      sm_act          <= 1'b0;
      ser_serial_data <= '0;
      ser_done        <= 1'b0;
    end
  end

  // Requesters release req when they see their ack.
  always @(negedge clk) begin
    if (ack != '0) req = req & ~ack;
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [10:0] e;
    logic [3:0]  a;
    cyc++;
    if (out_valid) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_elem: got %0h expected none", {out_src, out_last, out_data});
      end else begin
        e = exp_q.pop_front();
        check("out_elem", {out_src, out_last, out_data}, e);
      end
    end else begin
      check("idle_out_zero", {out_src, out_last, out_data}, 0);
    end
    if (ack != '0) begin
      ack_times.push_back(cyc);
      if (ack_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_ack: got %0h expected none", ack);
      end else begin
        a = ack_q.pop_front();
        check("ack", ack, a);
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed stimulus ----------------
  initial begin
    reset_n  = 1'b0;
    req      = '0;
    req_data = '0;
    done_at  = FEATURES - 1;
    repeat (2) @(negedge clk);
    check("reset_outputs",
          {ack, ser_start, ser_parallel_data, out_valid, out_data, out_src, out_last, err}, 0);
    check("reset_state", state_dbg, 0);
    reset_n = 1'b1;
    tick();

    // Single request: start at t+1, elements t+2..t+5, ack at t+6.
    set_slice(0, 32'h04030201);
    push_elem(2'd0, 8'h01, 1'b0);
    push_elem(2'd0, 8'h02, 1'b0);
    push_elem(2'd0, 8'h03, 1'b0);
    push_elem(2'd0, 8'h04, 1'b1);
    ack_q.push_back(4'b0001);
    req = 4'b0001;
    tick();
    check("t1_start", ser_start, 1);
    check("t1_par", ser_parallel_data, 32'h04030201);
    tick();
    check("t1_start_one_cycle", ser_start, 0);
    repeat (4) tick();
    check("t1_ack_t6", ack, 4'b0001);
    drain(40);

    // All four from reset: grants 0,1,2,3 and acks 7 cycles apart.
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    ack_times.delete();
    set_slice(0, 32'h00000000);
    set_slice(1, 32'h01010101);
    set_slice(2, 32'h02020202);
    set_slice(3, 32'h03030303);
    push_vec(2'd0, 32'h00000000);
    push_vec(2'd1, 32'h01010101);
    push_vec(2'd2, 32'h02020202);
    push_vec(2'd3, 32'h03030303);
    req = 4'b1111;
    drain(100);
    check("t2_ack_count", ack_times.size(), 4);
    if (ack_times.size() == 4) begin
      for (int i = 1; i < 4; i++) check("t2_ack_spacing", ack_times[i] - ack_times[i-1], 7);
    end

    // Fairness: serve 2 (ptr -> 3), then 0 and 2 together -> 0 first.
    set_slice(2, 32'hA4A3A2A1);
    push_vec(2'd2, 32'hA4A3A2A1);
    req = 4'b0100;
    drain(40);
    set_slice(0, 32'h14131211);
    push_vec(2'd0, 32'h14131211);
    push_vec(2'd2, 32'hA4A3A2A1);
    req = 4'b0101;
    drain(60);

    // Requester 1 drops req during STREAM; transfer still completes.
    set_slice(1, 32'hDDCCBBAA);
    push_vec(2'd1, 32'hDDCCBBAA);
    req = 4'b0010;
    tick();
    tick();
    req = 4'b0000;
    drain(40);

    // Reset after element 2 of requester 2 (ptr is 2 at this point).
    set_slice(2, 32'h77665544);
    push_elem(2'd2, 8'h44, 1'b0);
    push_elem(2'd2, 8'h55, 1'b0);
    push_elem(2'd2, 8'h66, 1'b0);
    req = 4'b0100;
    repeat (4) tick();
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    req     = '0;
    #1;
    check("abort_outputs",
          {ack, ser_start, ser_parallel_data, out_valid, out_data, out_src, out_last, err}, 0);
    check("abort_elems_seen", exp_q.size(), 0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    check("abort_state_idle", state_dbg, 0);
    // ptr back at 0: requester 0 beats 3.
    set_slice(0, 32'h0F0E0D0C);
    set_slice(3, 32'h3C3B3A39);
    push_vec(2'd0, 32'h0F0E0D0C);
    push_vec(2'd3, 32'h3C3B3A39);
    req = 4'b1001;
    drain(60);

    // Protocol check: ser_done early on element 2.
    check("err_clean", err, 0);
    done_at = 2;
    set_slice(0, 32'h88776655);
    push_vec(2'd0, 32'h88776655);
    req = 4'b0001;
    repeat (4) tick();
    check("err_before_violation", err, 0);
    tick();
    check("err_after_violation", err, ERR_EN);
    drain(40);
    check("err_sticky", err, ERR_EN);
    done_at = FEATURES - 1;
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    check("err_cleared_by_reset", err, 0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/serializer_arbiter.md
# serializer_arbiter

Round-robin scheduler that shares one `serializer` instance between `NUM_REQ` LSTM gate-vector producers. It accepts a full parallel vector from the winning requester and drives it into the serializer with a one-cycle `start`. It then tags the returned serial element stream with the requester index and acknowledges the requester when its vector has been fully emitted. The block sits between the gate datapaths and the single serializer feeding the downstream element-wise stage.

## Interface
- `NUM_REQ`, 4, number of requesters.
- `ELEMENT_BITS`, 8, bits per element.
- `FEATURES`, 4, elements per vector.
- `clk`  in  1  single clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `req`  in  NUM_REQ  per-requester request level; held with data until `ack`.
- `req_data`  in  NUM_REQ*ELEMENT_BITS*FEATURES  vectors; requester i occupies slice i.
- `ack`  out  NUM_REQ  one-cycle pulse to the served requester at completion.
- `ser_start`  out  1  start pulse to the serializer.
- `ser_parallel_data`  out  ELEMENT_BITS*FEATURES  vector to the serializer.
- `ser_serial_data`  in  ELEMENT_BITS  element from the serializer.
- `ser_done`  in  1  serializer done, high with the last element.
- `out_valid`  out  1  `out_data` is a valid element.
- `out_data`  out  ELEMENT_BITS  element forwarded to the consumer.
- `out_src`  out  $clog2(NUM_REQ)  index of the requester owning the element.
- `out_last`  out  1  marks the last element of a vector.
- `err`  out  1  sticky protocol error (see Configuration).

## Operation
- FSM has four states: IDLE, LOAD, STREAM, ACK.
- **IDLE:**
  - If any `req` is high, the round-robin arbiter picks the first requester at or after `ptr`.
  - The grant index is registered and its slice is latched into `ser_parallel_data`.
  - Next state is LOAD.
- **LOAD:**
  - `ser_start`=1 for exactly this cycle.
  - Element counter `cnt` is cleared.
  - Next state is STREAM.
- **STREAM:**
  - The serializer protocol is fixed: element k appears on `ser_serial_data` in cycle k+1 after the `start` cycle.
  - Each STREAM cycle, `out_valid`=1, `out_data`=`ser_serial_data`, `out_src`=grant, and `cnt` increments.
  - When `cnt`==FEATURES-1: `out_last`=1 and next state is ACK.
- **ACK:**
  - `ack[grant]`=1 for one cycle.
  - `ptr` becomes grant+1, wrapping modulo NUM_REQ.
  - Next state is IDLE.
- `ser_parallel_data` is held stable from LOAD through ACK.
- A requester dropping `req` mid-transfer is ignored: the transfer completes and `ack` still pulses.
- A requester still holding `req` during ACK is not re-granted until the IDLE cycle.
- `cnt` width is $clog2(FEATURES+1).
- `out_data` is passed through combinationally, gated by `out_valid`, and is 0 when not valid.

## Timing
- Reset (asynchronous, on `reset_n` low): state=IDLE, `ptr`=0, `cnt`=0, grant=0. All outputs are 0: `ack`, `ser_start`, `ser_parallel_data`, `out_valid`, `out_data`, `out_src`, `out_last`, `err`.
- Reset asserted mid-operation aborts the transfer with no `ack`. The serializer is reset by the same `reset_n`.
- Latency, with `req` sampled in IDLE at edge t:
  - `ser_start` high in cycle t+1.
  - Elements valid in cycles t+2 .. t+1+FEATURES.
  - `ack` in cycle t+2+FEATURES.
  - Earliest next grant at edge t+3+FEATURES.
- Throughput is one vector per FEATURES+3 cycles.
- Simultaneous requests are resolved by `ptr` only. No starvation: every pending requester is served within NUM_REQ grants.

## Configuration
- Macro `SER_ARB_ERR_CHK_EN`.
- **Defined:** in the STREAM cycle where `cnt`==FEATURES-1, `ser_done` must be 1. In every other STREAM cycle, and in IDLE, LOAD and ACK, `ser_done` must be 0. Any violation sets `err`, which holds until reset. The FSM sequence is unaffected.
- **Undefined:** `err` is tied to 0, `ser_done` is unused, and no checker logic is synthesized.

## Structure
- Package `ser_arb_pkg` holds:
  - State enum `ser_arb_state_t` {IDLE, LOAD, STREAM, ACK}.
  - Default-width localparams `SER_ELEMENT_BITS`=8 and `SER_FEATURES`=4.
- Sub-module `rr_arbiter`:
  - Parameter NUM_REQ.
  - Inputs `req` and `ptr`; outputs `gnt_idx` and `gnt_valid`.
  - Purely combinational; `ptr` and all state stay in the top module.

## Test plan
- **Single request:** `req`=4'b0001, slice0=32'h04030201.
  - `ser_start` in cycle t+1.
  - `out_data` 01,02,03,04 with `out_src`=0 and `out_last` on 04.
  - `ack`=4'b0001 at t+6.
- **All four requesting from reset:** slice i=32'h0i0i0i0i. Grants in order 0,1,2,3, each with the correct `out_src`; four `ack` pulses spaced 7 cycles apart.
- **Fairness:** serve requester 2, then raise `req`=4'b0101 → requester 0 is granted next, then 2.
- **Requester drops `req` during STREAM:** all 4 elements are still emitted and `ack` still pulses.
- **Reset mid-STREAM (after element 2):**
  - All outputs are 0 immediately; no `ack`.
  - `ptr`=0 after release.
  - A fresh request is served normally.
- **With `SER_ARB_ERR_CHK_EN`:** model asserts `ser_done` on element 2 instead of element 3 → `err`=1 from the next cycle and it stays 1. Without the macro, `err` stays 0.
